// File: rtl/lc3b_types.sv
// Shared lc3b types plus the fetch-stage FSM state and prefetch entry layout.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } if_state_t;

  typedef struct packed {
    lc3b_word ir;
    lc3b_word plus2;
  } if_entry_t;

  function automatic lc3b_word word_align(input lc3b_word addr);
    return addr & 16'hFFFE;
  endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch queue between instruction memory and the DE handoff.
// Flush beats push; a full queue still accepts a push when it pops in the same cycle.
module if_prefetch_fifo
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  if_entry_t              push_data,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output if_entry_t              head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if_entry_t     mem_q [DEPTH];
  if_entry_t     mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// lc3b instruction-fetch stage: PC, single-outstanding memory read FSM, prefetch queue.
// Optional IF_FETCH_PERF_EN adds saturating fetch/stall/drop performance counters.
module if_fetch_unit
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter lc3b_word    RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_address,
  output logic        mem_read,
  input  logic [15:0] mem_rdata,
  input  logic        mem_resp,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        if_valid_out,
  output logic [15:0] if_ir_out,
  output logic [15:0] if_plus2_out
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt,
  output logic [15:0] perf_drop_cnt
`endif
);

  if_state_t state_q, state_d;
  lc3b_word  pc_q, pc_d;
  lc3b_word  req_pc_q, req_pc_d;

  logic                   fifo_push, fifo_pop, resp_drop;
  logic                   fifo_empty, fifo_full_unused, slot_free;
  logic [$clog2(DEPTH):0] fifo_count;
  if_entry_t              fifo_head, fifo_push_data;

  assign slot_free      = (32'(fifo_count) < DEPTH);
  assign fifo_pop       = !fifo_empty && !stall;
  assign fifo_push_data = '{ir: mem_rdata, plus2: req_pc_q + 16'd2};

  assign mem_read     = (state_q != IDLE);
  assign mem_address  = word_align((state_q == IDLE) ? pc_q : req_pc_q);
  assign if_valid_out = !fifo_empty;
  assign if_ir_out    = fifo_head.ir;
  assign if_plus2_out = fifo_head.plus2;

  // Redirect overrides every state-local PC update; a response landing with a redirect is discarded.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    fifo_push = 1'b0;
    resp_drop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect && slot_free) begin
          state_d  = REQ;
          req_pc_d = pc_q;
        end
      end
      REQ: begin
        if (mem_resp) begin
          state_d = IDLE;
          if (redirect) begin
            resp_drop = 1'b1;
          end else begin
            fifo_push = 1'b1;
            pc_d      = req_pc_q + 16'd2;
          end
        end else if (redirect) begin
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_resp) begin
          state_d   = IDLE;
          resp_drop = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      pc_d = word_align(redirect_pc);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= word_align(RESET_PC);
      req_pc_q <= word_align(RESET_PC);
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
    end
  end

  if_prefetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(fifo_push_data),
    .pop      (fifo_pop),
    .flush    (redirect),
    .full     (fifo_full_unused),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head     (fifo_head)
  );

`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    drop_cnt_d  = drop_cnt_q;
    if (fifo_push && (fetch_cnt_q != '1)) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (if_valid_out && stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (resp_drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
  assign perf_drop_cnt  = drop_cnt_q;
`else
  logic unused_resp_drop;
  assign unused_resp_drop = resp_drop;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: memory responder, in-order fetch-stream reference, directed and random steps.
module tb_if_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, mem_read, mem_resp, stall, redirect, if_valid_out;
  logic [15:0] mem_address, mem_rdata, redirect_pc, if_ir_out, if_plus2_out;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
  logic [15:0] perf_drop_cnt;
`endif

  int          checks   = 0;
  int          failures = 0;
  int          mem_lat  = 1;
  bit          rand_lat = 1'b0;
  int          popped   = 0;
  logic [15:0] addr_q[$];
  logic [15:0] p2_q[$];

  if_fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid_out(if_valid_out),
    .if_ir_out   (if_ir_out),
    .if_plus2_out(if_plus2_out)
`ifdef IF_FETCH_PERF_EN
    ,
    .perf_fetch_cnt(perf_fetch_cnt),
    .perf_stall_cnt(perf_stall_cnt),
    .perf_drop_cnt (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  // Memory: one response per request after mem_lat extra cycles; abandons on reset.
  initial begin : memory
    int          lat_cnt;
    logic [15:0] lat_addr;
    lat_cnt   = -1;
    lat_addr  = '0;
    mem_resp  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset || mem_resp) begin
        mem_resp = 1'b0;
        lat_cnt  = -1;
      end else if (mem_read === 1'b1) begin
        if (lat_cnt < 0) begin
          lat_cnt  = rand_lat ? int'($urandom_range(0, 3)) : mem_lat;
          lat_addr = mem_address;
          check("addr_even", 32'(mem_address[0]), 32'd0);
        end else begin
          check("addr_stable", 32'(mem_address), 32'(lat_addr));
        end
        if (lat_cnt == 0) begin
          mem_resp  = 1'b1;
          mem_rdata = mem_word(mem_address);
        end else begin
          lat_cnt--;
        end
      end
    end
  end

  // Reference: DE must see consecutive words from the last reset/redirect target, nothing else.
  initial begin : monitor
    logic [15:0] exp_pc, nxt;
    bit          exp_empty;
    exp_pc    = RESET_PC;
    exp_empty = 1'b0;
    forever begin
      @(negedge clk);
      if (exp_empty) check("flush_valid", 32'(if_valid_out), 32'd0);
      exp_empty = 1'b0;
      if (if_valid_out === 1'b0) begin
        check("empty_ir", 32'(if_ir_out), 32'd0);
        check("empty_plus2", 32'(if_plus2_out), 32'd0);
      end
      if (reset) begin
        exp_pc    = RESET_PC & 16'hFFFE;
        exp_empty = 1'b1;
      end else if (redirect) begin
        exp_pc    = redirect_pc & 16'hFFFE;
        exp_empty = 1'b1;
      end else if (if_valid_out === 1'b1 && !stall) begin
        nxt = exp_pc + 16'd2;
        check("stream_plus2", 32'(if_plus2_out), 32'(nxt));
        check("stream_ir", 32'(if_ir_out), 32'(mem_word(exp_pc)));
        exp_pc = nxt;
        popped++;
      end
    end
  end

  task automatic collect(input int n, input int budget, input bit chk_lat);
    logic prev_rd, prev_resp;
    addr_q.delete();
    p2_q.delete();
    prev_rd   = mem_read;
    prev_resp = mem_resp;
    for (int c = 0; c < budget && (addr_q.size() < n || p2_q.size() < n); c++) begin
      tick();
      if (chk_lat && prev_resp) check("resp_to_valid", 32'(if_valid_out), 32'd1);
      if (mem_read && !prev_rd) addr_q.push_back(mem_address);
      if (if_valid_out && !stall) p2_q.push_back(if_plus2_out);
      prev_rd   = mem_read;
      prev_resp = mem_resp;
    end
  endtask

  task automatic expect_seq(input string tag, input int idx, input logic [15:0] ea,
                            input logic [15:0] ep);
    logic [31:0] a, p;
    a = (idx < addr_q.size()) ? 32'(addr_q[idx]) : 32'hxxxx_xxxx;
    p = (idx < p2_q.size()) ? 32'(p2_q[idx]) : 32'hxxxx_xxxx;
    check({tag, "_addr"}, a, 32'(ea));
    check({tag, "_plus2"}, p, 32'(ep));
  endtask

  task automatic wait_new_req(input string tag);
    logic prev;
    bit   ok;
    prev = mem_read;
    ok   = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (mem_read && !prev) ok = 1'b1;
      prev = mem_read;
    end
    check(tag, 32'(ok), 32'd1);
  endtask

  initial begin : stimulus
    logic [15:0] old_addr;
    int          n;
    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    repeat (3) tick();
    check("rst_mem_read", 32'(mem_read), 32'd0);
    check("rst_valid", 32'(if_valid_out), 32'd0);
    check("rst_ir", 32'(if_ir_out), 32'd0);
    check("rst_plus2", 32'(if_plus2_out), 32'd0);
    check("rst_addr", 32'(mem_address), 32'(RESET_PC));
    reset = 1'b0;

    // 1: sequential fetch from reset
    mem_lat = 1;
    collect(3, 60, 1'b1);
    for (int i = 0; i < 3; i++) expect_seq("t1", i, 16'(2 * i), 16'(2 * i + 2));

    // 2: stall fills exactly DEPTH entries then stops issuing
    stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i >= 7) check("t2_no_read", 32'(mem_read), 32'd0);
    end
    check("t2_valid_held", 32'(if_valid_out), 32'd1);
    stall = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (!if_valid_out) break;
      n++;
      tick();
    end
    check("t2_depth", 32'(n), 32'(DEPTH));

    // 3: redirect mid-request; stale response arrives 3 cycles later
    mem_lat = 3;
    wait_new_req("t3_req");
    old_addr    = mem_address;
    redirect    = 1'b1;
    redirect_pc = 16'h3000;
    tick();
    redirect = 1'b0;
    check("t3_drop_read", 32'(mem_read), 32'd1);
    check("t3_addr_hold", 32'(mem_address), 32'(old_addr));
    for (int i = 0; i < 10; i++) begin
      if (!mem_read) break;
      check("t3_no_valid", 32'(if_valid_out), 32'd0);
      tick();
    end
    check("t3_drop_done", 32'(mem_read), 32'd0);
    check("t3_discarded", 32'(if_valid_out), 32'd0);
    collect(1, 40, 1'b0);
    expect_seq("t3", 0, 16'h3000, 16'h3002);

    // 4: redirect coincident with mem_resp
    mem_lat = 2;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (mem_resp) break;
    end
    check("t4_resp_seen", 32'(mem_resp), 32'd1);
    redirect    = 1'b1;
    redirect_pc = 16'h5A40;
    tick();
    redirect = 1'b0;
    check("t4_idle_read", 32'(mem_read), 32'd0);
    check("t4_no_push", 32'(if_valid_out), 32'd0);
    check("t4_idle_addr", 32'(mem_address), 32'h5A40);
    tick();
    check("t4_req_read", 32'(mem_read), 32'd1);
    check("t4_req_addr", 32'(mem_address), 32'h5A40);

    // 5: PC wrap
    mem_lat     = 1;
    redirect    = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    collect(2, 60, 1'b0);
    expect_seq("t5_0", 0, 16'hFFFE, 16'h0000);
    expect_seq("t5_1", 1, 16'h0000, 16'h0002);

    // 6: reset while a request is outstanding
    mem_lat = 3;
    wait_new_req("t6_req");
    reset = 1'b1;
    tick();
    check("t6_mem_read", 32'(mem_read), 32'd0);
    check("t6_valid", 32'(if_valid_out), 32'd0);
    check("t6_addr", 32'(mem_address), 32'(RESET_PC));
`ifdef IF_FETCH_PERF_EN
    check("t6_perf_fetch", perf_fetch_cnt, 32'd0);
    check("t6_perf_stall", perf_stall_cnt, 32'd0);
    check("t6_perf_drop", 32'(perf_drop_cnt), 32'd0);
`endif
    reset = 1'b0;

    // Random traffic against the stream reference
    rand_lat = 1'b1;
    n        = popped;
    for (int i = 0; i < 4000; i++) begin
      stall       = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 30) == 0);
      redirect_pc = 16'($urandom);
      reset       = ($urandom_range(0, 499) == 0);
      tick();
    end
    stall    = 1'b0;
    redirect = 1'b0;
    reset    = 1'b0;
    repeat (10) tick();
    check("rand_progress", 32'(popped - n > 300), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
